// File: rtl/lockstep_proxy_voter.sv
// Lockstep broadcast voter: picks one of NUM_MODULES buses, cross-checks the rest against it,
// latches modules that keep disagreeing as faulted and decodes the proxy SFR write/read strobes.

module lockstep_proxy_voter #(
   parameter int                NUM_MODULES   = 4,
   parameter int                ADDR_W        = 16,
   parameter int                DATA_W        = 8,
   parameter int                STRB_W        = 8,
   parameter int                FAULT_THRESH  = 3,
   parameter logic [STRB_W-1:0] WR_STROBE     = 8'h11,
   parameter logic [ADDR_W-1:0] PROXY_WR_ADDR = 16'h00C1,
   parameter logic [ADDR_W-1:0] PROXY_AD_ADDR = 16'h00C2,
   localparam int               SEL_W         = $clog2(NUM_MODULES)
) (
   input  logic                          CORE_CLK,
   input  logic                          RST_n,
   input  logic [NUM_MODULES-1:0]        MODULE_OK,
   input  logic [NUM_MODULES*STRB_W-1:0] MODULE_STROBE,
   input  logic [NUM_MODULES*ADDR_W-1:0] MODULE_ADDRESS,
   input  logic [NUM_MODULES*DATA_W-1:0] MODULE_DATA,
   input  logic                          SEL_MODE,
   input  logic [NUM_MODULES-1:0]        FAULT_CLEAR,
   output logic [STRB_W-1:0]             TOP_STROBE,
   output logic [ADDR_W-1:0]             TOP_ADDRESS,
   output logic [DATA_W-1:0]             TOP_DATA,
   output logic                          SEL_VALID,
   output logic [SEL_W-1:0]              SEL_INDEX,
   output logic                          FAILOVER,
   output logic [NUM_MODULES-1:0]        MODULE_FAULT,
   output logic [15:0]                   MISMATCH_EVENTS,
   output logic                          PROXY_WR,
   output logic                          PROXY_RD,
   output logic [DATA_W-1:0]             PROXY_ADDRESS,
   output logic [DATA_W-1:0]             PROXY_WR_DATA
);

   localparam int                BUS_W     = STRB_W + ADDR_W + DATA_W;
   localparam logic [3:0]        THRESH_C  = 4'(FAULT_THRESH);
   localparam logic [SEL_W:0]    NUM_C     = (SEL_W+1)'(NUM_MODULES);
   localparam logic [STRB_W-1:0] STRB_FILL = STRB_W'({(STRB_W+3)/4{4'hE}});
   localparam logic [ADDR_W-1:0] ADDR_FILL = ADDR_W'({(ADDR_W+3)/4{4'hE}});
   localparam logic [DATA_W-1:0] DATA_FILL = DATA_W'({(DATA_W+3)/4{4'hE}});

   // Index base+off modulo NUM_MODULES, used to walk upward from the previous selection.
   function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] base, input int off);
      logic [SEL_W:0] sum_v;
      sum_v = {1'b0, base} + (SEL_W+1)'(off);
      return (sum_v >= NUM_C) ? SEL_W'(sum_v - NUM_C) : sum_v[SEL_W-1:0];
   endfunction

   logic [BUS_W-1:0]       bus_s [NUM_MODULES];
   logic [BUS_W-1:0]       sel_bus_s;
   logic [NUM_MODULES-1:0] eligible_s;
   logic [NUM_MODULES-1:0] mismatch_s;
   logic                   any_mismatch_s;
   logic                   valid_s;
   logic [SEL_W-1:0]       fixed_sel_s;
   logic [SEL_W-1:0]       sticky_sel_s;
   logic [SEL_W-1:0]       sel_s;
   logic [STRB_W-1:0]      top_strobe_s;
   logic [ADDR_W-1:0]      top_address_s;
   logic [DATA_W-1:0]      top_data_s;
   logic                   wr_hit_s;
   logic                   rd_hit_s;

   logic [SEL_W-1:0]       sel_index_r;
   logic                   sel_valid_r;
   logic                   failover_r;
   logic [NUM_MODULES-1:0] fault_r;
   logic [3:0]             cnt_r [NUM_MODULES];
   logic [15:0]            events_r;
   logic                   proxy_wr_r;
   logic                   proxy_rd_r;
   logic [DATA_W-1:0]      proxy_addr_r;
   logic [DATA_W-1:0]      proxy_wr_data_r;

   assign eligible_s = MODULE_OK & ~fault_r;
   assign valid_s    = |eligible_s;

   for (genvar g = 0; g < NUM_MODULES; g++) begin : g_module
      assign bus_s[g] = {MODULE_STROBE[g*STRB_W +: STRB_W],
                         MODULE_ADDRESS[g*ADDR_W +: ADDR_W],
                         MODULE_DATA[g*DATA_W +: DATA_W]};
      // The selected module is the reference, so it can never mismatch itself.
      assign mismatch_s[g] = eligible_s[g] & (sel_s != SEL_W'(g)) & (bus_s[g] != sel_bus_s);
   end

   assign any_mismatch_s = |mismatch_s;

   // Selection: fixed = lowest eligible; sticky = keep previous, else next eligible upward.
   always_comb begin
      fixed_sel_s = '0;
      for (int i = NUM_MODULES - 1; i >= 0; i--) begin
         fixed_sel_s = eligible_s[i] ? SEL_W'(i) : fixed_sel_s;
      end
      sticky_sel_s = fixed_sel_s;
      for (int k = NUM_MODULES - 1; k >= 1; k--) begin
         sticky_sel_s = eligible_s[wrap_inc(sel_index_r, k)] ? wrap_inc(sel_index_r, k) : sticky_sel_s;
      end
      sticky_sel_s = eligible_s[sel_index_r] ? sel_index_r : sticky_sel_s;
      sel_s        = SEL_MODE ? sticky_sel_s : fixed_sel_s;
   end

   assign sel_bus_s     = bus_s[sel_s];
   assign top_strobe_s  = valid_s ? sel_bus_s[BUS_W-1 -: STRB_W]        : STRB_FILL;
   assign top_address_s = valid_s ? sel_bus_s[DATA_W +: ADDR_W]         : ADDR_FILL;
   assign top_data_s    = valid_s ? sel_bus_s[DATA_W-1:0]               : DATA_FILL;

   assign wr_hit_s = valid_s & (top_strobe_s == WR_STROBE) & (top_address_s == PROXY_WR_ADDR);
   assign rd_hit_s = valid_s & (top_strobe_s == WR_STROBE) & (top_address_s == PROXY_AD_ADDR);

   // Selection history and failover pulse.
   always_ff @(posedge CORE_CLK or negedge RST_n) begin
      if (!RST_n) begin
         sel_index_r <= '0;
         sel_valid_r <= 1'b0;
         failover_r  <= 1'b0;
      end else begin
         sel_valid_r <= valid_s;
         failover_r  <= sel_valid_r & (~valid_s | (sel_s != sel_index_r));
         if (valid_s) begin
            sel_index_r <= sel_s;
         end
      end
   end

   // Per-module consecutive-mismatch counters and latched fault flags; clear wins.
   always_ff @(posedge CORE_CLK or negedge RST_n) begin
      if (!RST_n) begin
         fault_r <= '0;
         for (int i = 0; i < NUM_MODULES; i++) begin
            cnt_r[i] <= 4'd0;
         end
      end else begin
         for (int i = 0; i < NUM_MODULES; i++) begin
            if (FAULT_CLEAR[i]) begin
               fault_r[i] <= 1'b0;
               cnt_r[i]   <= 4'd0;
            end else if (!eligible_s[i]) begin
               cnt_r[i] <= fault_r[i] ? cnt_r[i] : 4'd0;
            end else if (mismatch_s[i]) begin
               cnt_r[i]   <= cnt_r[i] + 4'd1;
               fault_r[i] <= ((cnt_r[i] + 4'd1) == THRESH_C);
            end else begin
               cnt_r[i] <= 4'd0;
            end
         end
      end
   end

   // Saturating count of cycles where any module disagreed.
   always_ff @(posedge CORE_CLK or negedge RST_n) begin
      if (!RST_n) begin
         events_r <= 16'd0;
      end else if (any_mismatch_s && (events_r != 16'hFFFF)) begin
         events_r <= events_r + 16'd1;
      end
   end

   // Proxy SFR decode, one cycle behind the forwarded bus.
   always_ff @(posedge CORE_CLK or negedge RST_n) begin
      if (!RST_n) begin
         proxy_wr_r      <= 1'b0;
         proxy_rd_r      <= 1'b0;
         proxy_addr_r    <= '0;
         proxy_wr_data_r <= '0;
      end else begin
         proxy_wr_r <= wr_hit_s;
         proxy_rd_r <= rd_hit_s;
         if (wr_hit_s) begin
            proxy_wr_data_r <= top_data_s;
         end
         if (rd_hit_s) begin
            proxy_addr_r <= top_data_s;
         end
      end
   end

   assign TOP_STROBE      = top_strobe_s;
   assign TOP_ADDRESS     = top_address_s;
   assign TOP_DATA        = top_data_s;
   assign SEL_VALID       = sel_valid_r;
   assign SEL_INDEX       = sel_index_r;
   assign FAILOVER        = failover_r;
   assign MODULE_FAULT    = fault_r;
   assign MISMATCH_EVENTS = events_r;
   assign PROXY_WR        = proxy_wr_r;
   assign PROXY_RD        = proxy_rd_r;
   assign PROXY_ADDRESS   = proxy_addr_r;
   assign PROXY_WR_DATA   = proxy_wr_data_r;

endmodule

// File: tb/tb_lockstep_proxy_voter.sv
// Scoreboard bench for lockstep_proxy_voter: expected values are queued as stimulus is
// driven and popped when the DUT output is sampled one time unit after the clock edge.

module tb_lockstep_proxy_voter;

   logic        core_clk;
   logic        rst_n;
   logic [3:0]  module_ok;
   logic [31:0] module_strobe;
   logic [63:0] module_address;
   logic [31:0] module_data;
   logic        sel_mode;
   logic [3:0]  fault_clear;
   logic [7:0]  top_strobe;
   logic [15:0] top_address;
   logic [7:0]  top_data;
   logic        sel_valid;
   logic [1:0]  sel_index;
   logic        failover;
   logic [3:0]  module_fault;
   logic [15:0] mismatch_events;
   logic        proxy_wr;
   logic        proxy_rd;
   logic [7:0]  proxy_address;
   logic [7:0]  proxy_wr_data;

   logic [9:0]  status_s;
   logic [31:0] exp_q [$];
   logic [31:0] exp_v;
   int          checks;
   int          errors;

   lockstep_proxy_voter dut (
      .CORE_CLK        (core_clk),
      .RST_n           (rst_n),
      .MODULE_OK       (module_ok),
      .MODULE_STROBE   (module_strobe),
      .MODULE_ADDRESS  (module_address),
      .MODULE_DATA     (module_data),
      .SEL_MODE        (sel_mode),
      .FAULT_CLEAR     (fault_clear),
      .TOP_STROBE      (top_strobe),
      .TOP_ADDRESS     (top_address),
      .TOP_DATA        (top_data),
      .SEL_VALID       (sel_valid),
      .SEL_INDEX       (sel_index),
      .FAILOVER        (failover),
      .MODULE_FAULT    (module_fault),
      .MISMATCH_EVENTS (mismatch_events),
      .PROXY_WR        (proxy_wr),
      .PROXY_RD        (proxy_rd),
      .PROXY_ADDRESS   (proxy_address),
      .PROXY_WR_DATA   (proxy_wr_data)
   );

   assign status_s = {proxy_wr, proxy_rd, sel_valid, failover, sel_index, module_fault};

   initial begin
      core_clk = 1'b0;
      forever #5 core_clk = ~core_clk;
   end

   function automatic logic [31:0] st(input logic wr, rd, v, fo, input logic [1:0] idx,
                                      input logic [3:0] flt);
      return {22'd0, wr, rd, v, fo, idx, flt};
   endfunction

   task automatic tick();
      @(posedge core_clk);
      #1;
   endtask

   task automatic set_all(input logic [7:0] s, input logic [15:0] a, input logic [7:0] d);
      for (int i = 0; i < 4; i++) begin
         module_strobe[i*8 +: 8]   = s;
         module_address[i*16 +: 16] = a;
         module_data[i*8 +: 8]     = d;
      end
   endtask

   task automatic test_reset();
      #12;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'hEEEEEEEE);
      exp_v = exp_q.pop_front(); checks++;
      if ({22'd0, status_s} !== exp_v) begin errors++; $display("FAIL reset_status: got %h expected %h", status_s, exp_v[9:0]); end
      exp_v = exp_q.pop_front(); checks++;
      if ({16'd0, mismatch_events} !== exp_v) begin errors++; $display("FAIL reset_events: got %h expected %h", mismatch_events, exp_v[15:0]); end
      exp_v = exp_q.pop_front(); checks++;
      if ({16'd0, proxy_address, proxy_wr_data} !== exp_v) begin errors++; $display("FAIL reset_proxy_regs: got %h expected %h", {proxy_address, proxy_wr_data}, exp_v[15:0]); end
      exp_v = exp_q.pop_front(); checks++;
      if ({top_strobe, top_address, top_data} !== exp_v) begin errors++; $display("FAIL reset_top_fill: got %h expected %h", {top_strobe, top_address, top_data}, exp_v); end
      rst_n = 1'b1;
      #4;
   endtask

   task automatic test_proxy();
      logic [7:0]  s_t  [5] = '{8'h11, 8'h11, 8'h11, 8'h22, 8'h00};
      logic [15:0] a_t  [5] = '{16'h00C2, 16'h00C1, 16'h00C3, 16'h00C1, 16'h0000};
      logic [7:0]  d_t  [5] = '{8'h15, 8'h5A, 8'h77, 8'h66, 8'h00};
      logic        wr_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic        rd_t [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [15:0] pr_t [5] = '{16'h1500, 16'h155A, 16'h155A, 16'h155A, 16'h155A};
      module_ok = 4'hF;
      sel_mode  = 1'b0;
      for (int r = 0; r < 5; r++) begin
         set_all(s_t[r], a_t[r], d_t[r]);
         exp_q.push_back({s_t[r], a_t[r], d_t[r]});
         exp_q.push_back(st(wr_t[r], rd_t[r], 1'b1, 1'b0, 2'd0, 4'h0));
         exp_q.push_back({16'd0, pr_t[r]});
         #1;
         exp_v = exp_q.pop_front(); checks++;
         if ({top_strobe, top_address, top_data} !== exp_v) begin errors++; $display("FAIL proxy_top row %0d: got %h expected %h", r, {top_strobe, top_address, top_data}, exp_v); end
         tick();
         exp_v = exp_q.pop_front(); checks++;
         if ({22'd0, status_s} !== exp_v) begin errors++; $display("FAIL proxy_status row %0d: got %h expected %h", r, status_s, exp_v[9:0]); end
         exp_v = exp_q.pop_front(); checks++;
         if ({16'd0, proxy_address, proxy_wr_data} !== exp_v) begin errors++; $display("FAIL proxy_regs row %0d: got %h expected %h", r, {proxy_address, proxy_wr_data}, exp_v[15:0]); end
      end
   endtask

   task automatic test_fault();
      logic [3:0]  clr_t [15] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0,
                                  4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      logic [7:0]  d2_t  [15] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01,
                                  8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00};
      logic [3:0]  flt_t [15] = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h4,
                                  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      logic [15:0] ev_t  [15] = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd4, 16'd5, 16'd6,
                                  16'd6, 16'd7, 16'd8, 16'd8, 16'd9, 16'd10, 16'd10};
      set_all(8'h00, 16'h0000, 8'h00);
      for (int r = 0; r < 15; r++) begin
         fault_clear        = clr_t[r];
         module_data[23:16] = d2_t[r];
         exp_q.push_back(st(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, flt_t[r]));
         exp_q.push_back({16'd0, ev_t[r]});
         tick();
         exp_v = exp_q.pop_front(); checks++;
         if ({22'd0, status_s} !== exp_v) begin errors++; $display("FAIL fault_status row %0d: got %h expected %h", r, status_s, exp_v[9:0]); end
         exp_v = exp_q.pop_front(); checks++;
         if ({16'd0, mismatch_events} !== exp_v) begin errors++; $display("FAIL fault_events row %0d: got %0d expected %0d", r, mismatch_events, exp_v); end
      end
      fault_clear = 4'h0;
   endtask

   task automatic test_fixed_failover();
      logic [3:0] ok_t  [4] = '{4'hE, 4'hE, 4'hF, 4'hF};
      logic [7:0] d0_t  [4] = '{8'h77, 8'h77, 8'h00, 8'h00};
      logic [1:0] idx_t [4] = '{2'd1, 2'd1, 2'd0, 2'd0};
      logic       fo_t  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      sel_mode = 1'b0;
      for (int r = 0; r < 4; r++) begin
         module_ok        = ok_t[r];
         module_data[7:0] = d0_t[r];
         exp_q.push_back(32'd0);
         exp_q.push_back(st(1'b0, 1'b0, 1'b1, fo_t[r], idx_t[r], 4'h0));
         exp_q.push_back(32'd10);
         #1;
         exp_v = exp_q.pop_front(); checks++;
         if ({24'd0, top_data} !== exp_v) begin errors++; $display("FAIL fixed_top_data row %0d: got %h expected %h", r, top_data, exp_v[7:0]); end
         tick();
         exp_v = exp_q.pop_front(); checks++;
         if ({22'd0, status_s} !== exp_v) begin errors++; $display("FAIL fixed_status row %0d: got %h expected %h", r, status_s, exp_v[9:0]); end
         exp_v = exp_q.pop_front(); checks++;
         if ({16'd0, mismatch_events} !== exp_v) begin errors++; $display("FAIL fixed_events row %0d: got %0d expected %0d", r, mismatch_events, exp_v); end
      end
   endtask

   task automatic test_sticky();
      logic [3:0] ok_t   [7] = '{4'h8, 4'hF, 4'h7, 4'hF, 4'hC, 4'hB, 4'hF};
      logic       mode_t [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       wr_t   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [1:0] idx_t  [7] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0};
      logic       fo_t   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [7:0] wd_t   [7] = '{8'h5A, 8'h5A, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44};
      for (int r = 0; r < 7; r++) begin
         module_ok = ok_t[r];
         sel_mode  = mode_t[r];
         if (wr_t[r]) begin
            set_all(8'h11, 16'h00C1, 8'h44);
            module_data[31:24] = 8'h33;
         end else begin
            set_all(8'h00, 16'h0000, 8'h00);
         end
         exp_q.push_back(st(wr_t[r], 1'b0, 1'b1, fo_t[r], idx_t[r], 4'h0));
         exp_q.push_back({24'd0, wd_t[r]});
         exp_q.push_back(32'd10);
         tick();
         exp_v = exp_q.pop_front(); checks++;
         if ({22'd0, status_s} !== exp_v) begin errors++; $display("FAIL sticky_status row %0d: got %h expected %h", r, status_s, exp_v[9:0]); end
         exp_v = exp_q.pop_front(); checks++;
         if ({24'd0, proxy_wr_data} !== exp_v) begin errors++; $display("FAIL sticky_wr_data row %0d: got %h expected %h", r, proxy_wr_data, exp_v[7:0]); end
         exp_v = exp_q.pop_front(); checks++;
         if ({16'd0, mismatch_events} !== exp_v) begin errors++; $display("FAIL sticky_events row %0d: got %0d expected %0d", r, mismatch_events, exp_v); end
      end
   endtask

   task automatic test_none_and_reset();
      logic [3:0] flt_t [3] = '{4'h0, 4'h0, 4'h2};
      sel_mode  = 1'b0;
      module_ok = 4'h0;
      set_all(8'h11, 16'h00C1, 8'h99);
      exp_q.push_back(32'hEEEEEEEE);
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if ({top_strobe, top_address, top_data} !== exp_v) begin errors++; $display("FAIL none_top_fill: got %h expected %h", {top_strobe, top_address, top_data}, exp_v); end
      for (int r = 0; r < 2; r++) begin
         exp_q.push_back(st(1'b0, 1'b0, 1'b0, (r == 0), 2'd0, 4'h0));
         exp_q.push_back(32'h44);
         tick();
         exp_v = exp_q.pop_front(); checks++;
         if ({22'd0, status_s} !== exp_v) begin errors++; $display("FAIL none_status row %0d: got %h expected %h", r, status_s, exp_v[9:0]); end
         exp_v = exp_q.pop_front(); checks++;
         if ({24'd0, proxy_wr_data} !== exp_v) begin errors++; $display("FAIL none_wr_data row %0d: got %h expected %h", r, proxy_wr_data, exp_v[7:0]); end
      end
      module_ok = 4'hF;
      set_all(8'h11, 16'h00C1, 8'h21);
      module_data[15:8] = 8'h22;
      for (int r = 0; r < 3; r++) begin
         exp_q.push_back(st(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, flt_t[r]));
         exp_q.push_back(32'd11 + 32'(r));
         tick();
         exp_v = exp_q.pop_front(); checks++;
         if ({22'd0, status_s} !== exp_v) begin errors++; $display("FAIL prereset_status row %0d: got %h expected %h", r, status_s, exp_v[9:0]); end
         exp_v = exp_q.pop_front(); checks++;
         if ({16'd0, mismatch_events} !== exp_v) begin errors++; $display("FAIL prereset_events row %0d: got %0d expected %0d", r, mismatch_events, exp_v); end
      end
      #2;
      rst_n = 1'b0;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if ({22'd0, status_s} !== exp_v) begin errors++; $display("FAIL midreset_status: got %h expected %h", status_s, exp_v[9:0]); end
      exp_v = exp_q.pop_front(); checks++;
      if ({16'd0, mismatch_events} !== exp_v) begin errors++; $display("FAIL midreset_events: got %h expected %h", mismatch_events, exp_v[15:0]); end
      exp_v = exp_q.pop_front(); checks++;
      if ({16'd0, proxy_address, proxy_wr_data} !== exp_v) begin errors++; $display("FAIL midreset_proxy_regs: got %h expected %h", {proxy_address, proxy_wr_data}, exp_v[15:0]); end
      set_all(8'h00, 16'h0000, 8'h00);
      #3;
      rst_n = 1'b1;
      exp_q.push_back(st(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0));
      exp_q.push_back(32'd0);
      tick();
      exp_v = exp_q.pop_front(); checks++;
      if ({22'd0, status_s} !== exp_v) begin errors++; $display("FAIL postreset_status: got %h expected %h", status_s, exp_v[9:0]); end
      exp_v = exp_q.pop_front(); checks++;
      if ({16'd0, mismatch_events} !== exp_v) begin errors++; $display("FAIL postreset_events: got %h expected %h", mismatch_events, exp_v[15:0]); end
   endtask

   task automatic test_saturate();
      module_data[23:16] = 8'h01;
      fault_clear        = 4'h4;
      for (int n = 0; n < 65534; n++) begin
         tick();
      end
      exp_q.push_back(32'hFFFE);
      exp_q.push_back(st(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0));
      exp_v = exp_q.pop_front(); checks++;
      if ({16'd0, mismatch_events} !== exp_v) begin errors++; $display("FAIL sat_events_pre: got %h expected %h", mismatch_events, exp_v[15:0]); end
      exp_v = exp_q.pop_front(); checks++;
      if ({22'd0, status_s} !== exp_v) begin errors++; $display("FAIL sat_status: got %h expected %h", status_s, exp_v[9:0]); end
      exp_q.push_back(32'hFFFF);
      tick();
      exp_v = exp_q.pop_front(); checks++;
      if ({16'd0, mismatch_events} !== exp_v) begin errors++; $display("FAIL sat_events_hit: got %h expected %h", mismatch_events, exp_v[15:0]); end
      exp_q.push_back(32'hFFFF);
      repeat (5) tick();
      exp_v = exp_q.pop_front(); checks++;
      if ({16'd0, mismatch_events} !== exp_v) begin errors++; $display("FAIL sat_events_hold: got %h expected %h", mismatch_events, exp_v[15:0]); end
      fault_clear        = 4'h0;
      module_data[23:16] = 8'h00;
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst_n          = 1'b0;
      module_ok      = 4'h0;
      fault_clear    = 4'h0;
      sel_mode       = 1'b0;
      module_strobe  = 32'd0;
      module_address = 64'd0;
      module_data    = 32'd0;
      test_reset();
      test_proxy();
      test_fault();
      test_fixed_failover();
      test_sticky();
      test_none_and_reset();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
